// File: rtl/ddr_axi_pkg.sv
// Shared types, AXI encodings and helpers for the DDR AXI burst master.
package ddr_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BRESP,
    S_RDATA,
    S_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/ddr_axi_burst_calc.sv
// Burst sizing: min(remaining beats, MAX_BURST, beats left before the next 4 KB boundary).
module ddr_axi_burst_calc
  import ddr_axi_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int MAX_BURST = 256
) (
  input  logic [11:0] addr_lo,
  input  logic [15:0] remain,
  output logic [8:0]  beats
);

  localparam int SIZE_LOG = log2(DATA_W / 8);

  logic [16:0] to_bound;
  logic [16:0] cap;

  always_comb begin
    to_bound = 17'((13'h1000 - {1'b0, addr_lo}) >> SIZE_LOG);
    cap      = {1'b0, remain};
    if (cap > 17'(MAX_BURST)) cap = 17'(MAX_BURST);
    if (cap > to_bound)       cap = to_bound;
    beats    = 9'(cap);
  end

endmodule

// File: rtl/ddr_axi_burst_master.sv
// AXI4 burst master turning beat-count commands into 4 KB-safe INCR bursts.
// Optional macro DDR_AXI_ERR_CHECK_EN enables the sticky per-command op_err flag.
module ddr_axi_burst_master
  import ddr_axi_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 49,
  parameter int ID_W      = 6,
  parameter int MAX_BURST = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rd,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [15:0]                   cmd_beats,
  input  logic [log2(DATA_W/8)-1:0]     cmd_last_bytes,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          rd_last,
  output logic                          op_done,
  output logic                          op_err,
  output logic                          busy,
  output logic [ID_W-1:0]               m_axi_awid,
  output logic [ADDR_W-1:0]             m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [DATA_W-1:0]             m_axi_wdata,
  output logic [DATA_W/8-1:0]           m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [ID_W-1:0]               m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [ID_W-1:0]               m_axi_arid,
  output logic [ADDR_W-1:0]             m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [ID_W-1:0]               m_axi_rid,
  input  logic [DATA_W-1:0]             m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  localparam int BYTES    = DATA_W / 8;
  localparam int SIZE_LOG = log2(BYTES);

  state_t                state, next_state;
  logic                  rd_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [15:0]           remain_q;
  logic [SIZE_LOG-1:0]   last_bytes_q;
  logic [8:0]            burst_q, beat_cnt_q, calc_beats;
  logic                  avalid_q;
  logic                  in_w, in_r, cmd_fire, a_fire, w_fire, b_fire, r_fire;
  logic                  wlast, last_cmd_beat;

  ddr_axi_burst_calc #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) u_calc (
    .addr_lo (addr_q[11:0]),
    .remain  (remain_q),
    .beats   (calc_beats)
  );

  assign in_w     = (state == S_WDATA);
  assign in_r     = (state == S_RDATA);
  assign cmd_fire = cmd_valid && (state == S_IDLE);
  assign a_fire   = avalid_q && (rd_q ? m_axi_arready : m_axi_awready);
  assign w_fire   = in_w && wr_valid && m_axi_wready;
  assign b_fire   = (state == S_BRESP) && m_axi_bvalid;
  assign r_fire   = in_r && m_axi_rvalid && rd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (cmd_valid) next_state = (cmd_beats == 16'd0) ? S_DONE : S_ADDR;
      S_ADDR:  if (a_fire) next_state = rd_q ? S_RDATA : S_WDATA;
      S_WDATA: if (w_fire && wlast) next_state = S_BRESP;
      S_BRESP: if (b_fire) next_state = (remain_q != 16'd0) ? S_ADDR : S_DONE;
      S_RDATA: if (r_fire && m_axi_rlast) next_state = (remain_q != 16'd0) ? S_ADDR : S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Burst size is latched on the first ADDR cycle so the address phase stays stable until ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q         <= 1'b0;
      addr_q       <= '0;
      remain_q     <= '0;
      last_bytes_q <= '0;
      burst_q      <= '0;
      beat_cnt_q   <= '0;
      avalid_q     <= 1'b0;
    end else begin
      if (cmd_fire) begin
        rd_q         <= cmd_rd;
        addr_q       <= cmd_addr;
        remain_q     <= cmd_beats;
        last_bytes_q <= cmd_last_bytes;
      end
      if (state == S_ADDR && !avalid_q) begin
        avalid_q   <= 1'b1;
        burst_q    <= calc_beats;
        beat_cnt_q <= calc_beats;
      end else if (a_fire) begin
        avalid_q <= 1'b0;
        addr_q   <= addr_q + (ADDR_W'(burst_q) << SIZE_LOG);
        remain_q <= remain_q - 16'(burst_q);
      end
      if (w_fire) beat_cnt_q <= beat_cnt_q - 9'd1;
    end
  end

  assign wlast         = (beat_cnt_q == 9'd1);
  assign last_cmd_beat = wlast && (remain_q == 16'd0);

  always_comb begin
    m_axi_wstrb = '1;
    if (last_cmd_beat)
      for (int unsigned i = 0; i < BYTES; i++)
        m_axi_wstrb[i] = (SIZE_LOG'(i) <= last_bytes_q);
  end

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign op_done       = (state == S_DONE);

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(burst_q - 9'd1);
  assign m_axi_awsize  = 3'(SIZE_LOG);
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = '0;
  assign m_axi_awprot  = '0;
  assign m_axi_awqos   = '0;
  assign m_axi_awvalid = avalid_q && !rd_q;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(burst_q - 9'd1);
  assign m_axi_arsize  = 3'(SIZE_LOG);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = '0;
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign m_axi_arvalid = avalid_q && rd_q;

  assign m_axi_wdata   = wr_data;
  assign m_axi_wvalid  = in_w && wr_valid;
  assign m_axi_wlast   = wlast;
  assign wr_ready      = in_w && m_axi_wready;
  assign m_axi_bready  = (state == S_BRESP);

  assign m_axi_rready  = in_r && rd_ready;
  assign rd_valid      = in_r && m_axi_rvalid;
  assign rd_data       = m_axi_rdata;
  assign rd_last       = in_r && m_axi_rlast && (remain_q == 16'd0);

`ifdef DDR_AXI_ERR_CHECK_EN
  logic err_q;
  logic unused_ids;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            err_q <= 1'b0;
    else if (cmd_fire)  err_q <= 1'b0;
    else if ((b_fire && m_axi_bresp != RESP_OKAY) || (r_fire && m_axi_rresp != RESP_OKAY))
      err_q <= 1'b1;
  end

  assign op_err     = err_q;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};
`else
  logic unused_resp;
  assign op_err      = 1'b0;
  assign unused_resp = ^{m_axi_bid, m_axi_rid, m_axi_bresp, m_axi_rresp, b_fire};
`endif

endmodule

// File: tb/tb_ddr_axi_burst_master.sv
// Randomized bench: behavioural burst-split model plus AXI slave and host stream models.
module tb_ddr_axi_burst_master;
  import ddr_axi_pkg::*;

  localparam int DATA_W = 128, ADDR_W = 49, ID_W = 6, MAX_BURST = 256, BYTES = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic cmd_valid, cmd_ready, cmd_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [3:0] cmd_last_bytes;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic wr_valid, wr_ready, rd_valid, rd_ready, rd_last, op_done, op_err, busy;
  logic [ID_W-1:0] awid, arid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0] awcache, arcache, awqos, arqos;
  logic [DATA_W-1:0] wdata, rdata;
  logic [BYTES-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  ddr_axi_burst_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_last_bytes(cmd_last_bytes),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .op_done(op_done), .op_err(op_err), .busy(busy),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache), .m_axi_awprot(awprot),
    .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bid('0), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid('0), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  typedef struct { logic [ADDR_W-1:0] addr; int len; } burst_t;

  burst_t exp_aw[$], exp_ar[$], wq[$], rq[$];
  logic [DATA_W-1:0] host_w[$];
  logic [DATA_W:0] exp_rd[$];
  int w_beat, r_beat, b_pending, b_idx, err_burst, w_seen, cmd_total, done_cnt;
  logic [3:0] cur_lb;
  logic [31:0] salt;
  logic err_at_done;
  bit cmd_fire_f, w_fire_f, b_fire_f, r_fire_f;

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [31:0] s);
    return {a[31:0] ^ s, ~a[31:0], s, a[31:0] + s};
  endfunction

  function automatic logic [BYTES-1:0] strb_mask(input logic [3:0] lb);
    return 16'((32'd1 << (32'(lb) + 1)) - 32'd1);
  endfunction

  task automatic clear_model();
    exp_aw.delete(); exp_ar.delete(); wq.delete(); rq.delete(); host_w.delete(); exp_rd.delete();
    w_beat = 0; r_beat = 0; b_pending = 0; b_idx = 0; w_seen = 0;
    cmd_fire_f = 0; w_fire_f = 0; b_fire_f = 0; r_fire_f = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    cmd_valid = 0; cmd_rd = 0; cmd_addr = '0; cmd_beats = '0; cmd_last_bytes = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0; awready = 0; arready = 0; wready = 0;
    bvalid = 0; bresp = RESP_OKAY; rvalid = 0; rlast = 0; rdata = '0; rresp = RESP_OKAY;
    clear_model();
    repeat (2) @(negedge clk);
    check_eq("reset_hold", 160'({cmd_ready, busy, op_done, op_err, awvalid, arvalid, wvalid,
             bready, rready, rd_valid, wr_ready}), 160'(11'b100_0000_0000));
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_release", 160'({cmd_ready, busy, op_done, op_err, awvalid, arvalid, wvalid,
             bready, rready, rd_valid, wr_ready}), 160'(11'b100_0000_0000));
  endtask

  task automatic drive();
    awready  = ($urandom % 2) == 0;
    arready  = ($urandom % 2) == 0;
    wready   = ($urandom % 4) != 0;
    rd_ready = ($urandom % 2) == 0;
    if (cmd_fire_f) cmd_valid = 1'b0;
    if (b_fire_f) bvalid = 1'b0;
    if (!bvalid && b_pending > 0 && ($urandom % 2) == 0) begin
      bvalid = 1'b1;
      bresp  = (b_idx == err_burst) ? RESP_SLVERR : RESP_OKAY;
    end
    if (r_fire_f) rvalid = 1'b0;
    if (!rvalid && rq.size() > 0 && ($urandom % 2) == 0) begin
      rvalid = 1'b1;
      rdata  = pat(rq[0].addr + ADDR_W'(r_beat * BYTES), salt);
      rlast  = (r_beat == rq[0].len);
    end
    if (w_fire_f) wr_valid = 1'b0;
    if (!wr_valid && host_w.size() > 0 && ($urandom % 3) != 0) begin
      wr_valid = 1'b1;
      wr_data  = host_w[0];
    end
    cmd_fire_f = 0; w_fire_f = 0; b_fire_f = 0; r_fire_f = 0;
  endtask

  task automatic sample();
    burst_t x;
    logic [BYTES-1:0] es;
    cmd_fire_f = cmd_valid && cmd_ready;
    if (awvalid && awready) begin
      check_eq("aw_expected", 160'(exp_aw.size() != 0), 160'(1));
      if (exp_aw.size() != 0) begin
        check_eq("aw", 160'({awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awid}),
                 160'({exp_aw[0].addr, 8'(exp_aw[0].len), 3'd4, 2'b01, 12'd0, 6'd0}));
        void'(exp_aw.pop_front());
      end
      x.addr = awaddr; x.len = int'(awlen);
      wq.push_back(x);
    end
    if (wvalid && wready) begin
      check_eq("w_expected", 160'(wq.size() != 0 && host_w.size() != 0), 160'(1));
      if (wq.size() != 0 && host_w.size() != 0) begin
        es = (w_seen == cmd_total - 1) ? strb_mask(cur_lb) : '1;
        check_eq("w_beat", 160'({wlast, wstrb, wdata}), 160'({w_beat == wq[0].len, es, host_w[0]}));
        void'(host_w.pop_front());
        w_seen++;
        if (w_beat == wq[0].len) begin
          void'(wq.pop_front()); w_beat = 0; b_pending++;
        end else w_beat++;
      end
      w_fire_f = 1;
    end
    if (bvalid && bready) begin
      b_pending--; b_idx++; b_fire_f = 1;
    end
    if (arvalid && arready) begin
      check_eq("ar_expected", 160'(exp_ar.size() != 0), 160'(1));
      if (exp_ar.size() != 0) begin
        check_eq("ar", 160'({araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid}),
                 160'({exp_ar[0].addr, 8'(exp_ar[0].len), 3'd4, 2'b01, 12'd0, 6'd0}));
        void'(exp_ar.pop_front());
      end
      x.addr = araddr; x.len = int'(arlen);
      rq.push_back(x);
    end
    if (rvalid && rready && rq.size() != 0) begin
      if (r_beat == rq[0].len) begin
        void'(rq.pop_front()); r_beat = 0;
      end else r_beat++;
      r_fire_f = 1;
    end
    if (rd_valid && rd_ready) begin
      check_eq("rd_expected", 160'(exp_rd.size() != 0), 160'(1));
      if (exp_rd.size() != 0) begin
        check_eq("rd_beat", 160'({rd_last, rd_data}), 160'(exp_rd[0]));
        void'(exp_rd.pop_front());
      end
    end
    if (op_done) begin
      done_cnt++;
      err_at_done = op_err;
    end
  endtask

  task automatic run_cmd(input bit rd, input logic [ADDR_W-1:0] addr, input int beats,
                         input logic [3:0] lb, input int err_b, input int rst_at);
    logic [ADDR_W-1:0] a;
    int r, b, room, nb, cyc, budget;
    logic exp_err;
    burst_t x;
    clear_model();
    a = addr; r = beats; nb = 0;
    while (r > 0) begin
      room = (4096 - int'(a[11:0])) / BYTES;
      b = r;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > room) b = room;
      x.addr = a; x.len = b - 1;
      if (rd) exp_ar.push_back(x); else exp_aw.push_back(x);
      a = a + ADDR_W'(b * BYTES); r -= b; nb++;
    end
    salt = $urandom;
    for (int i = 0; i < beats; i++) begin
      if (rd) exp_rd.push_back({i == beats - 1, pat(addr + ADDR_W'(i * BYTES), salt)});
      else host_w.push_back({$urandom, $urandom, $urandom, $urandom});
    end
`ifdef DDR_AXI_ERR_CHECK_EN
    exp_err = !rd && err_b >= 0 && err_b < nb;
`else
    exp_err = 1'b0;
`endif
    cmd_total = beats; cur_lb = lb; err_burst = rd ? -1 : err_b;
    done_cnt = 0; err_at_done = 1'b0; cyc = 0; budget = 40 * beats + 200;
    @(negedge clk);
    cmd_rd = rd; cmd_addr = addr; cmd_beats = 16'(beats); cmd_last_bytes = lb; cmd_valid = 1'b1;
    while (done_cnt == 0 && cyc < budget) begin
      drive(); #3; sample(); cyc++;
      if (rst_at >= 0 && w_seen == rst_at) begin
        rst = 1'b1; #1;
        check_eq("rst_async", 160'({awvalid, wvalid, wr_ready, bready, busy, op_done}), 160'(0));
        reset_dut();
        return;
      end
      @(negedge clk);
    end
    check_eq("op_done_count", 160'(done_cnt), 160'(1));
    if (done_cnt == 0) begin
      reset_dut();
      return;
    end
    check_eq("op_err", 160'(err_at_done), 160'(exp_err));
    check_eq("leftover", 160'(exp_aw.size() + exp_ar.size() + host_w.size() + exp_rd.size()), 160'(0));
    @(negedge clk); drive(); #3;
    check_eq("idle_after", 160'({op_done, busy, cmd_ready}), 160'(3'b001));
  endtask

  initial begin
    int nr;
    reset_dut();
    run_cmd(0, 49'h0, 16, 4'd15, -1, -1);
    run_cmd(1, 49'hF80, 16, 4'd0, -1, -1);
    run_cmd(0, 49'h10000, 600, 4'd7, 1, -1);
    run_cmd(0, 49'h0, 0, 4'd0, -1, -1);
    run_cmd(0, 49'h2340, 1, 4'd3, -1, -1);
    run_cmd(1, 49'h2340, 1, 4'd0, -1, -1);
    run_cmd(1, 49'h7FF0, 40, 4'd0, -1, -1);
    run_cmd(0, 49'h30000, 40, 4'd5, -1, 6);
    run_cmd(0, 49'h30000, 20, 4'd9, -1, -1);
    for (int k = 0; k < 12; k++) begin
      nr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 700) : $urandom_range(1, 40);
      run_cmd(1'($urandom % 2), ADDR_W'({$urandom_range(0, 32'hFFFF), 4'b0}), nr,
              4'($urandom), (($urandom % 3) == 0) ? $urandom_range(0, 2) : -1, -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
